move_sequencer: RTL and testbench

Move-command queue and sequencer for the stepper datapath. It buffers coordinated-move commands decoded from SPI words (direction, duration, increment, increment-increment) in a small FIFO so the host can stream moves back to back. It then issues the moves one at a time to the step-generation engine. For each move it loads the engine's parameters, emits one engine tick every `clock_divisor` clocks for `duration` ticks, and reports completion.

---
 rtl/move_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Move-command FIFO and sequencer: queues coordinated moves and plays each one out to the
// step engine as a load strobe followed by divided ticks. MOVE_SEQUENCER_DIR_SETUP_EN adds a direction-setup dwell.
module move_sequencer #(
   parameter int DEPTH     = 4,
   parameter int DIR_SETUP = 16
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_dir,
   input  logic [63:0]              cmd_duration,
   input  logic [63:0]              cmd_increment,
   input  logic [63:0]              cmd_incinc,
   input  logic [23:0]              clock_divisor,
   input  logic                     abort,
   output logic                     eng_load,
   output logic                     eng_dir,
   output logic [63:0]              eng_increment,
   output logic [63:0]              eng_incinc,
   output logic                     eng_tick,
   output logic                     busy,
   output logic                     move_done,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic [63:0]              ticks_remaining
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

   typedef struct packed {
      logic        dir;
      logic [63:0] dur;
      logic [63:0] inc;
      logic [63:0] incinc;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
      S_SETUP,
`endif
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   cmd_t          fifo_q [DEPTH];
   cmd_t          head;
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [PW:0]   count_q, count_d;
   logic [63:0]   ticks_q, ticks_d;
   logic [23:0]   presc_q, presc_d, div_q, div_d;
   logic          engDir_q, engDir_d, engLoad_q, engLoad_d;
   logic [63:0]   engInc_q, engInc_d, engIncinc_q, engIncinc_d;
   logic          push, pop, tickNow, doneNow;

`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
   localparam int SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
   localparam logic [SW-1:0] SetupLast = SW'(DIR_SETUP - 1);
   logic [SW-1:0] setup_q, setup_d;
`endif

   assign cmd_ready = (count_q != FullCount);
   assign push      = cmd_valid && cmd_ready && !abort;
   assign pop       = (state_q == S_LOAD);
   assign head      = fifo_q[rdPtr_q];

   // Abort wins over everything but reset, so it sits ahead of the FIFO and state updates.
   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      ticks_d     = ticks_q;
      presc_d     = presc_q;
      div_d       = div_q;
      engDir_d    = engDir_q;
      engInc_d    = engInc_q;
      engIncinc_d = engIncinc_q;
      engLoad_d   = 1'b0;
      tickNow     = 1'b0;
      doneNow     = 1'b0;
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
      setup_d     = setup_q;
`endif
      if (abort) begin
         state_d = S_IDLE;
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
         ticks_d = '0;
         presc_d = '0;
      end else begin
         if (push) wrPtr_d = wrPtr_q + PW'(1);
         if (pop)  rdPtr_d = rdPtr_q + PW'(1);
         if (push && !pop)      count_d = count_q + (PW+1)'(1);
         else if (!push && pop) count_d = count_q - (PW+1)'(1);

         case (state_q)
            S_IDLE: begin
               if (count_q != '0 || push) state_d = S_LOAD;
            end
            S_LOAD: begin
               engDir_d    = head.dir;
               engInc_d    = head.inc;
               engIncinc_d = head.incinc;
               engLoad_d   = 1'b1;
               div_d       = (clock_divisor == 24'd0) ? 24'd1 : clock_divisor;
               ticks_d     = head.dur;
               presc_d     = '0;
               if (head.dur == 64'd0) state_d = S_DONE;
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
               else if (head.dir != engDir_q && DIR_SETUP > 0) begin
                  state_d = S_SETUP;
                  setup_d = '0;
               end
`endif
               else state_d = S_RUN;
            end
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
            S_SETUP: begin
               if (setup_q == SetupLast) state_d = S_RUN;
               else setup_d = setup_q + SW'(1);
            end
`endif
            S_RUN: begin
               if (presc_q + 24'd1 == div_q) begin
                  tickNow = 1'b1;
                  presc_d = '0;
                  ticks_d = ticks_q - 64'd1;
                  if (ticks_q == 64'd1) state_d = S_DONE;
               end else begin
                  presc_d = presc_q + 24'd1;
               end
            end
            S_DONE: begin
               doneNow = 1'b1;
               state_d = (count_q != '0 || push) ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         ticks_q     <= '0;
         presc_q     <= '0;
         div_q       <= '0;
         engDir_q    <= 1'b0;
         engInc_q    <= '0;
         engIncinc_q <= '0;
         engLoad_q   <= 1'b0;
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
         setup_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         ticks_q     <= ticks_d;
         presc_q     <= presc_d;
         div_q       <= div_d;
         engDir_q    <= engDir_d;
         engInc_q    <= engInc_d;
         engIncinc_q <= engIncinc_d;
         engLoad_q   <= engLoad_d;
`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
         setup_q     <= setup_d;
`endif
      end
   end

   // Entry storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (push) fifo_q[wrPtr_q] <= '{dir: cmd_dir, dur: cmd_duration, inc: cmd_increment, incinc: cmd_incinc};
   end

   assign eng_load        = engLoad_q;
   assign eng_dir         = engDir_q;
   assign eng_increment   = engInc_q;
   assign eng_incinc      = engIncinc_q;
   assign eng_tick        = tickNow;
   assign move_done       = doneNow;
   assign busy            = (state_q != S_IDLE);
   assign queue_count     = count_q;
   assign ticks_remaining = ticks_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: DUT events are logged per cycle and compared with a schedule
// computed arithmetically from pushed commands (load at max(push+2, prevDone+2), ticks every div).
module tb_move_sequencer;

   logic        CLK = 1'b0;
   logic        reset, cmd_valid, cmd_ready, cmd_dir, abort;
   logic [63:0] cmd_duration, cmd_increment, cmd_incinc;
   logic [23:0] clock_divisor;
   logic        eng_load, eng_dir, eng_tick, busy, move_done;
   logic [63:0] eng_increment, eng_incinc, ticks_remaining;
   logic [2:0]  queue_count;

`ifdef MOVE_SEQUENCER_DIR_SETUP_EN
   localparam int SetupCyc = 16;
`else
   localparam int SetupCyc = 0;
`endif

   move_sequencer #(.DEPTH(4), .DIR_SETUP(16)) dut (
      .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_duration(cmd_duration), .cmd_increment(cmd_increment),
      .cmd_incinc(cmd_incinc), .clock_divisor(clock_divisor), .abort(abort),
      .eng_load(eng_load), .eng_dir(eng_dir), .eng_increment(eng_increment),
      .eng_incinc(eng_incinc), .eng_tick(eng_tick), .busy(busy), .move_done(move_done),
      .queue_count(queue_count), .ticks_remaining(ticks_remaining)
   );

   always #5 CLK = ~CLK;

   typedef struct {int cyc; int kind; logic [128:0] data;} ev_t;
   typedef struct {int cyc; int qc; logic rdy;} qc_t;

   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   logic         modelDir = 1'b0;
   ev_t          evLog[$], expEv[$];
   qc_t          qcLog[$];
   int           pushCyc[$], pushDur[$];
   logic [128:0] pushData[$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Kind 0 = eng_load (with params), 1 = eng_tick, 2 = move_done.
   always @(negedge CLK) begin
      if (!reset) begin
         ev_t e;
         qc_t q;
         if (eng_load) begin e.cyc = cyc; e.kind = 0; e.data = {eng_dir, eng_increment, eng_incinc}; evLog.push_back(e); end
         if (eng_tick) begin e.cyc = cyc; e.kind = 1; e.data = '0; evLog.push_back(e); end
         if (move_done) begin e.cyc = cyc; e.kind = 2; e.data = '0; evLog.push_back(e); end
         q.cyc = cyc; q.qc = int'(queue_count); q.rdy = cmd_ready;
         qcLog.push_back(q);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic startScenario();
      evLog.delete(); qcLog.delete(); pushCyc.delete(); pushData.delete(); pushDur.delete();
   endtask

   task automatic pushCmd(input logic dir, input logic [63:0] dur, input logic [63:0] inc, input logic [63:0] incinc);
      bit ok = 1'b0;
      cmd_valid = 1'b1; cmd_dir = dir; cmd_duration = dur; cmd_increment = inc; cmd_incinc = incinc;
      for (int w = 0; w < 100 && !ok; w++) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1) begin
            pushCyc.push_back(cyc); pushData.push_back({dir, inc, incinc}); pushDur.push_back(int'(dur[31:0]));
            ok = 1'b1;
         end
         @(posedge CLK); #1;
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("[TB] FAIL push handshake: cmd_ready=%b, want 1", cmd_ready);
      end
   endtask

   task automatic waitKind(input int kind, input int num, input int limit, output bit ok);
      int n;
      ok = 1'b0;
      for (int w = 0; w < limit && !ok; w++) begin
         @(posedge CLK); #1;
         n = 0;
         foreach (evLog[i]) if (evLog[i].kind == kind) n++;
         if (n >= num) ok = 1'b1;
      end
   endtask

   // Schedule model: each move loads 2 cycles after its push or after the previous done,
   // whichever is later; N ticks spaced div apart, done div cycles after the Nth tick window.
   task automatic buildModel(input int div);
      int d, start, prevDone, dn, s;
      logic dir;
      d = (div == 0) ? 1 : div;
      prevDone = -100;
      expEv.delete();
      for (int i = 0; i < pushCyc.size(); i++) begin
         ev_t e;
         start = (pushCyc[i] > prevDone) ? pushCyc[i] + 2 : prevDone + 2;
         e.cyc = start; e.kind = 0; e.data = pushData[i]; expEv.push_back(e);
         dir = pushData[i][128];
         if (pushDur[i] == 0) dn = start;
         else begin
            s = (dir != modelDir) ? SetupCyc : 0;
            for (int k = 0; k < pushDur[i]; k++) begin
               e.cyc = start + s + d - 1 + k * d; e.kind = 1; e.data = '0; expEv.push_back(e);
            end
            dn = start + s + pushDur[i] * d;
         end
         e.cyc = dn; e.kind = 2; e.data = '0; expEv.push_back(e);
         modelDir = dir;
         prevDone = dn;
      end
   endtask

   task automatic waitModelEnd();
      int endCyc;
      endCyc = expEv[expEv.size()-1].cyc + 4;
      while (cyc < endCyc) begin @(posedge CLK); #1; end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      modelDir = 1'b0;
      total++;
      if ({cmd_ready, eng_load, eng_tick, eng_dir, busy, move_done} !== 6'b100000) begin
         bad++; $display("[TB] FAIL reset flags: got %b want 100000", {cmd_ready, eng_load, eng_tick, eng_dir, busy, move_done});
      end
      total++;
      if ({eng_increment, eng_incinc} !== 128'd0) begin
         bad++; $display("[TB] FAIL reset params: got %h want 0", {eng_increment, eng_incinc});
      end
      total++;
      if (queue_count !== 3'd0) begin bad++; $display("[TB] FAIL reset count: got %0d want 0", queue_count); end
      total++;
      if (ticks_remaining !== 64'd0) begin bad++; $display("[TB] FAIL reset ticks: got %0d want 0", ticks_remaining); end
      @(posedge CLK); #1;
   endtask

   task automatic test_single_move();
      startScenario();
      clock_divisor = 24'd3;
      pushCmd(1'b1, 64'd5, 64'd100, -64'sd2);
      buildModel(3);
      waitModelEnd();
      total++;
      if (evLog.size() !== expEv.size()) begin bad++; $display("[TB] FAIL single count: got %0d want %0d", evLog.size(), expEv.size()); end
      for (int i = 0; i < expEv.size() && i < evLog.size(); i++) begin
         total++;
         if (evLog[i].cyc !== expEv[i].cyc || evLog[i].kind !== expEv[i].kind || evLog[i].data !== expEv[i].data) begin
            bad++; $display("[TB] FAIL single ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evLog[i].cyc, evLog[i].kind, evLog[i].data, expEv[i].cyc, expEv[i].kind, expEv[i].data);
         end
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single busy: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int expQc, sawFull;
      startScenario();
      clock_divisor = 24'd2;
      for (int m = 0; m < 6; m++) pushCmd(m[0], 64'd3, 64'(m * 11), 64'(m + 1000));
      buildModel(2);
      waitModelEnd();
      total++;
      if (evLog.size() !== expEv.size()) begin bad++; $display("[TB] FAIL b2b count: got %0d want %0d", evLog.size(), expEv.size()); end
      for (int i = 0; i < expEv.size() && i < evLog.size(); i++) begin
         total++;
         if (evLog[i].cyc !== expEv[i].cyc || evLog[i].kind !== expEv[i].kind || evLog[i].data !== expEv[i].data) begin
            bad++; $display("[TB] FAIL b2b ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evLog[i].cyc, evLog[i].kind, evLog[i].data, expEv[i].cyc, expEv[i].kind, expEv[i].data);
         end
      end
      sawFull = 0;
      foreach (qcLog[j]) begin
         expQc = 0;
         foreach (pushCyc[p]) if (pushCyc[p] < qcLog[j].cyc) expQc++;
         foreach (expEv[k]) if (expEv[k].kind == 0 && expEv[k].cyc <= qcLog[j].cyc) expQc--;
         if (qcLog[j].rdy === 1'b0) sawFull = 1;
         total++;
         if (qcLog[j].qc !== expQc || qcLog[j].rdy !== (expQc != 4)) begin
            bad++; $display("[TB] FAIL b2b queue cyc=%0d: got count=%0d ready=%b want count=%0d ready=%b", qcLog[j].cyc, qcLog[j].qc, qcLog[j].rdy, expQc, expQc != 4);
         end
      end
      total++;
      if (sawFull != 1) begin bad++; $display("[TB] FAIL b2b full: cmd_ready never dropped, got %0d want 1", sawFull); end
   endtask

   task automatic test_zero_and_div0();
      startScenario();
      clock_divisor = 24'd0;
      pushCmd(1'b0, 64'd0, 64'h1234, 64'h5678);
      pushCmd(1'b1, 64'd4, 64'hAAAA, 64'hBBBB);
      buildModel(0);
      waitModelEnd();
      total++;
      if (evLog.size() !== expEv.size()) begin bad++; $display("[TB] FAIL zero_div0 count: got %0d want %0d", evLog.size(), expEv.size()); end
      for (int i = 0; i < expEv.size() && i < evLog.size(); i++) begin
         total++;
         if (evLog[i].cyc !== expEv[i].cyc || evLog[i].kind !== expEv[i].kind || evLog[i].data !== expEv[i].data) begin
            bad++; $display("[TB] FAIL zero_div0 ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evLog[i].cyc, evLog[i].kind, evLog[i].data, expEv[i].cyc, expEv[i].kind, expEv[i].data);
         end
      end
   endtask

   task automatic test_div_change();
      bit ok;
      startScenario();
      clock_divisor = 24'd2;
      pushCmd(1'b0, 64'd4, 64'd7, 64'd9);
      buildModel(2);
      waitKind(0, 1, 20, ok);
      clock_divisor = 24'd5;
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL divchg load: got none want 1"); end
      waitModelEnd();
      total++;
      if (evLog.size() !== expEv.size()) begin bad++; $display("[TB] FAIL divchg count: got %0d want %0d", evLog.size(), expEv.size()); end
      for (int i = 0; i < expEv.size() && i < evLog.size(); i++) begin
         total++;
         if (evLog[i].cyc !== expEv[i].cyc || evLog[i].kind !== expEv[i].kind) begin
            bad++; $display("[TB] FAIL divchg ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", i, evLog[i].cyc, evLog[i].kind, expEv[i].cyc, expEv[i].kind);
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      int n;
      startScenario();
      clock_divisor = 24'd3;
      for (int m = 0; m < 3; m++) pushCmd(1'b1, 64'd10, 64'(m), 64'(m));
      modelDir = 1'b1;
      waitKind(1, 2, 60, ok);
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL abort tick2: got fewer than 2 ticks want 2"); end
      n = evLog.size();
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      @(negedge CLK);
      total++;
      if (queue_count !== 3'd0 || ticks_remaining !== 64'd0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL abort state: got count=%0d ticks=%0d busy=%b want 0 0 0", queue_count, ticks_remaining, busy);
      end
      repeat (40) @(posedge CLK);
      #1;
      total++;
      if (evLog.size() !== n) begin bad++; $display("[TB] FAIL abort quiet: got %0d events want %0d", evLog.size(), n); end
      cmd_valid = 1'b1; abort = 1'b1;
      @(posedge CLK); #1;
      cmd_valid = 1'b0; abort = 1'b0;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      total++;
      if (queue_count !== 3'd0 || busy !== 1'b0 || evLog.size() !== n) begin
         bad++; $display("[TB] FAIL abort push: got count=%0d busy=%b events=%0d want 0 0 %0d", queue_count, busy, evLog.size(), n);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_wide();
      bit ok;
      startScenario();
      clock_divisor = 24'd2;
      pushCmd(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
      waitKind(0, 1, 20, ok);
      @(negedge CLK);
      total++;
      if (!ok || ticks_remaining !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++; $display("[TB] FAIL wide start: got %h want ffffffffffffffff", ticks_remaining);
      end
      total++;
      if (eng_increment !== 64'h8000_0000_0000_0001 || eng_incinc !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         bad++; $display("[TB] FAIL wide params: got %h %h want 8000000000000001 fffffffffffffffe", eng_increment, eng_incinc);
      end
      repeat (2) @(negedge CLK);
      total++;
      if (ticks_remaining !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         bad++; $display("[TB] FAIL wide step: got %h want fffffffffffffffe", ticks_remaining);
      end
      @(posedge CLK); #1;
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      modelDir = 1'b0;
   endtask

   task automatic test_reset_mid_move();
      bit ok;
      startScenario();
      clock_divisor = 24'd2;
      pushCmd(1'b1, 64'd20, 64'hDEAD, 64'hBEEF);
      pushCmd(1'b1, 64'd20, 64'h1111, 64'h2222);
      waitKind(0, 1, 20, ok);
      repeat (3) @(posedge CLK);
      #1 reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      modelDir = 1'b0;
      @(negedge CLK);
      total++;
      if (!ok || {eng_dir, eng_increment, eng_incinc} !== 129'd0) begin
         bad++; $display("[TB] FAIL midreset params: got %h want 0", {eng_dir, eng_increment, eng_incinc});
      end
      total++;
      if (queue_count !== 3'd0 || ticks_remaining !== 64'd0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset state: got count=%0d ticks=%0d busy=%b want 0 0 0", queue_count, ticks_remaining, busy);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_random();
      int div, n, gap;
      for (int it = 0; it < 8; it++) begin
         startScenario();
         div = $urandom_range(0, 4);
         clock_divisor = 24'(div);
         n = $urandom_range(1, 6);
         for (int m = 0; m < n; m++) begin
            pushCmd(1'($urandom % 2), 64'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom});
            gap = $urandom_range(0, 4);
            repeat (gap) begin @(posedge CLK); #1; end
         end
         buildModel(div);
         waitModelEnd();
         total++;
         if (evLog.size() !== expEv.size()) begin bad++; $display("[TB] FAIL random%0d count: got %0d want %0d", it, evLog.size(), expEv.size()); end
         for (int i = 0; i < expEv.size() && i < evLog.size(); i++) begin
            total++;
            if (evLog[i].cyc !== expEv[i].cyc || evLog[i].kind !== expEv[i].kind || evLog[i].data !== expEv[i].data) begin
               bad++; $display("[TB] FAIL random%0d ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", it, i, evLog[i].cyc, evLog[i].kind, evLog[i].data, expEv[i].cyc, expEv[i].kind, expEv[i].data);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
      cmd_duration = '0; cmd_increment = '0; cmd_incinc = '0; clock_divisor = 24'd1;
      test_reset();
      test_single_move();
      test_back_to_back();
      test_zero_and_div0();
      test_div_change();
      test_abort();
      test_wide();
      test_reset_mid_move();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
